// File: rtl/boot_sequencer_if.sv
// Bus bundle between the boot sequencer, its boot EEPROM and the write targets.
// The sequencer connects through the master modport; a ROM/target model uses slave.
interface boot_sequencer_if #(
    parameter int ROM_ADDR_WIDTH = 17,
    parameter int NUM_TARGETS    = 3
) ();
    logic                      start;
    logic [7:0]                rom_data;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr;
    logic                      rom_n_oe;
    logic [7:0]                data;
    logic [15:0]               addr;
    logic [NUM_TARGETS-1:0]    n_we;
    logic                      n_booted;
    logic                      busy;
    logic                      error;

    modport master (
        input  start,
        input  rom_data,
        output rom_addr,
        output rom_n_oe,
        output data,
        output addr,
        output n_we,
        output n_booted,
        output busy,
        output error
    );

    modport slave (
        output start,
        output rom_data,
        input  rom_addr,
        input  rom_n_oe,
        input  data,
        input  addr,
        input  n_we,
        input  n_booted,
        input  busy,
        input  error
    );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: walks a segmented image in a byte-wide EEPROM and replays each
// payload byte as a SETUP/STROBE/HOLD write cycle onto one of NUM_TARGETS targets.
// Segment format: id, len_hi, len_lo, then len payload bytes; id 0xFF ends the image.
module boot_sequencer #(
    parameter int ROM_ADDR_WIDTH = 17,
    parameter int NUM_TARGETS    = 3,
    parameter int ROM_WAIT       = 1,
    parameter int AUTOSTART      = 1
) (
    input  logic             clk,
    input  logic             rst,
    boot_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_HDR_ID,
        S_HDR_LEN_HI,
        S_HDR_LEN_LO,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ROM_ADDR_WIDTH-1:0] ROM_LAST  = '1;
    localparam logic [2:0]                WAIT_LAST = 3'(ROM_WAIT - 1);
    localparam logic [7:0]                NUM_TGT8  = 8'(NUM_TARGETS);

    state_t                    state_q, state_d;
    state_t                    ret_q, ret_d;          // consumer of the byte being fetched
    logic [2:0]                wait_q, wait_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                      exhausted_q, exhausted_d; // last ROM location already read
    logic [7:0]                byte_q, byte_d;        // most recent header byte
    logic [7:0]                id_q, id_d;
    logic [7:0]                len_hi_q, len_hi_d;
    logic [15:0]               rem_q, rem_d;
    logic [15:0]               addr_q, addr_d;
    logic [7:0]                data_q, data_d;
    state_t                    fetch_state;

    // A further ROM read is impossible once the top address was consumed: abort instead of wrapping.
    assign fetch_state = exhausted_q ? S_ERROR : S_FETCH;

    // State and datapath registers, cleared asynchronously so outputs drop immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ret_q       <= S_HDR_ID;
            wait_q      <= '0;
            rom_addr_q  <= '0;
            exhausted_q <= 1'b0;
            byte_q      <= '0;
            id_q        <= '0;
            len_hi_q    <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wait_q      <= wait_d;
            rom_addr_q  <= rom_addr_d;
            exhausted_q <= exhausted_d;
            byte_q      <= byte_d;
            id_q        <= id_d;
            len_hi_q    <= len_hi_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Next-state and datapath update; every ROM read goes through FETCH and returns to ret_q.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        wait_d      = wait_q;
        rom_addr_d  = rom_addr_q;
        exhausted_d = exhausted_q;
        byte_d      = byte_q;
        id_d        = id_q;
        len_hi_d    = len_hi_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            S_IDLE: begin
                if ((AUTOSTART != 0) || bus.start) begin
                    state_d = fetch_state;
                    ret_d   = S_HDR_ID;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    if (ret_q == S_SETUP) begin
                        data_d = bus.rom_data;
                    end else begin
                        byte_d = bus.rom_data;
                    end
                    if (rom_addr_q == ROM_LAST) begin
                        exhausted_d = 1'b1;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                    end
                    state_d = ret_q;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_HDR_ID: begin
                if (byte_q == 8'hFF) begin
                    state_d = S_DONE;
                end else if (byte_q >= NUM_TGT8) begin
                    state_d = S_ERROR;
                end else begin
                    id_d    = byte_q;
                    state_d = fetch_state;
                    ret_d   = S_HDR_LEN_HI;
                    wait_d  = '0;
                end
            end
            S_HDR_LEN_HI: begin
                len_hi_d = byte_q;
                state_d  = fetch_state;
                ret_d    = S_HDR_LEN_LO;
                wait_d   = '0;
            end
            S_HDR_LEN_LO: begin
                addr_d  = '0;
                rem_d   = {len_hi_q, byte_q};
                state_d = fetch_state;
                ret_d   = ({len_hi_q, byte_q} == 16'd0) ? S_HDR_ID : S_SETUP;
                wait_d  = '0;
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                addr_d  = addr_q + 16'd1;
                rem_d   = rem_q - 16'd1;
                state_d = fetch_state;
                ret_d   = (rem_q == 16'd1) ? S_HDR_ID : S_SETUP;
                wait_d  = '0;
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_n_oe = (state_q != S_FETCH);
    assign bus.data     = data_q;
    assign bus.addr     = addr_q;
    assign bus.n_booted = (state_q != S_DONE);
    assign bus.error    = (state_q == S_ERROR);
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

    // One enable per target; only the selected target is pulled low, and only in STROBE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_we
            assign bus.n_we[gi] = !((state_q == S_STROBE) && (id_q == 8'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: instance A (defaults, 17-bit ROM, autostart) and
// instance B (4-bit ROM, ROM_WAIT=3, start on START), each with a ROM model and write logger.
module tb_boot_sequencer;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    boot_sequencer_if #(.ROM_ADDR_WIDTH(17), .NUM_TARGETS(3)) bus_a ();
    boot_sequencer_if #(.ROM_ADDR_WIDTH(4),  .NUM_TARGETS(3)) bus_b ();

    boot_sequencer #(.ROM_ADDR_WIDTH(17), .NUM_TARGETS(3), .ROM_WAIT(1), .AUTOSTART(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    boot_sequencer #(.ROM_ADDR_WIDTH(4), .NUM_TARGETS(3), .ROM_WAIT(3), .AUTOSTART(0))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [16];

    assign bus_a.rom_data = (bus_a.rom_n_oe || (bus_a.rom_addr >= 17'd64)) ? 8'h00 : mem_a[bus_a.rom_addr[5:0]];
    assign bus_b.rom_data = bus_b.rom_n_oe ? 8'h00 : mem_b[bus_b.rom_addr];

    // write logs and monitor state
    logic [7:0]  wr_tgt_a[$];
    logic [15:0] wr_addr_a[$];
    logic [7:0]  wr_data_a[$];
    int          onehot_err_a = 0;
    logic [7:0]  wr_tgt_b[$];
    logic [15:0] wr_addr_b[$];
    logic [7:0]  wr_data_b[$];
    int          onehot_err_b = 0;
    int          strobe_cyc_b[$];
    int          fetch_runs_b[$];
    int          run_b = 0;
    logic [3:0]  run_addr_b = '0;
    bit          seen_nonzero_b = 0;
    bit          wrapped_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.n_we != 3'b111) begin
                if ($countones(~bus_a.n_we) != 1) onehot_err_a++;
                for (int k = 0; k < 3; k++) begin
                    if (!bus_a.n_we[k]) begin
                        wr_tgt_a.push_back(8'(k));
                        wr_addr_a.push_back(bus_a.addr);
                        wr_data_a.push_back(bus_a.data);
                        $display("A write tgt=%0d addr=%04h data=%02h", k, bus_a.addr, bus_a.data);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_b.n_we != 3'b111) begin
                if ($countones(~bus_b.n_we) != 1) onehot_err_b++;
                strobe_cyc_b.push_back(cycle);
                for (int k = 0; k < 3; k++) begin
                    if (!bus_b.n_we[k]) begin
                        wr_tgt_b.push_back(8'(k));
                        wr_addr_b.push_back(bus_b.addr);
                        wr_data_b.push_back(bus_b.data);
                        $display("B write tgt=%0d addr=%04h data=%02h", k, bus_b.addr, bus_b.data);
                    end
                end
            end
            if (!bus_b.rom_n_oe) begin
                if (run_b > 0 && bus_b.rom_addr == run_addr_b) begin
                    run_b++;
                end else begin
                    if (run_b > 0) fetch_runs_b.push_back(run_b);
                    run_b = 1;
                    run_addr_b = bus_b.rom_addr;
                end
            end else if (run_b > 0) begin
                fetch_runs_b.push_back(run_b);
                run_b = 0;
            end
            if (rst_b) seen_nonzero_b = 0;
            else if (bus_b.rom_addr != 4'd0) seen_nonzero_b = 1;
            else if (seen_nonzero_b) wrapped_b = 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic load_a(input logic [7:0] img[$]);
        for (int i = 0; i < 64; i++) mem_a[i] = (i < img.size()) ? img[i] : 8'hFF;
    endtask

    task automatic load_b(input logic [7:0] img[$]);
        for (int i = 0; i < 16; i++) mem_b[i] = (i < img.size()) ? img[i] : 8'hFF;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr_tgt_a.delete(); wr_addr_a.delete(); wr_data_a.delete();
        onehot_err_a = 0;
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr_tgt_b.delete(); wr_addr_b.delete(); wr_data_b.delete();
        strobe_cyc_b.delete(); fetch_runs_b.delete();
        onehot_err_b = 0; run_b = 0; wrapped_b = 0;
        rst_b = 1'b0;
    endtask

    task automatic wait_end_a(input int budget, output bit timeout);
        timeout = 1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus_a.busy) begin timeout = 0; break; end
        end
    endtask

    task automatic wait_end_b(input int budget, output bit timeout);
        timeout = 1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus_b.busy) begin timeout = 0; break; end
        end
    endtask

    task automatic pulse_start_b();
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] img[$] = '{8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hFF};
        load_a(img);
        rst_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        vectors++; if (bus_a.n_we !== 3'b111) begin miscompares++; $display("FAIL reset_n_we: got %b required 111", bus_a.n_we); end
        vectors++; if (bus_a.n_booted !== 1'b1) begin miscompares++; $display("FAIL reset_n_booted: got %b required 1", bus_a.n_booted); end
        vectors++; if (bus_a.rom_n_oe !== 1'b1) begin miscompares++; $display("FAIL reset_rom_n_oe: got %b required 1", bus_a.rom_n_oe); end
        vectors++; if (bus_a.error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b required 0", bus_a.error); end
        vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", bus_a.busy); end
        // let the boot run partway, then assert reset between edges
        rst_a = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        vectors++; if (bus_a.rom_addr !== 17'd0) begin miscompares++; $display("FAIL async_rom_addr: got %h required 0", bus_a.rom_addr); end
        vectors++; if (bus_a.addr !== 16'd0 || bus_a.data !== 8'd0) begin miscompares++; $display("FAIL async_addr_data: got %h/%h required 0000/00", bus_a.addr, bus_a.data); end
        vectors++; if (bus_a.rom_n_oe !== 1'b1 || bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL async_oe_busy: got %b/%b required 1/0", bus_a.rom_n_oe, bus_a.busy); end
    endtask

    task automatic test_basic_image();
        logic [7:0] img[$] = '{8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hFF};
        bit to;
        load_a(img);
        reset_a();
        @(posedge clk); #1;
        vectors++; if (bus_a.rom_n_oe !== 1'b0 || bus_a.rom_addr !== 17'd0) begin miscompares++; $display("FAIL autostart: got oe=%b addr=%h required 0/0", bus_a.rom_n_oe, bus_a.rom_addr); end
        wait_end_a(100, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got timeout required completion"); end
        vectors++; if (wr_tgt_a.size() !== 2) begin miscompares++; $display("FAIL basic_count: got %0d required 2", wr_tgt_a.size()); end
        if (wr_tgt_a.size() == 2) begin
            vectors++; if (wr_tgt_a[0] !== 8'd0 || wr_addr_a[0] !== 16'h0000 || wr_data_a[0] !== 8'hAA) begin miscompares++; $display("FAIL basic_wr0: got %0d/%h/%h required 0/0000/aa", wr_tgt_a[0], wr_addr_a[0], wr_data_a[0]); end
            vectors++; if (wr_tgt_a[1] !== 8'd0 || wr_addr_a[1] !== 16'h0001 || wr_data_a[1] !== 8'hBB) begin miscompares++; $display("FAIL basic_wr1: got %0d/%h/%h required 0/0001/bb", wr_tgt_a[1], wr_addr_a[1], wr_data_a[1]); end
        end
        vectors++; if (bus_a.n_booted !== 1'b0 || bus_a.error !== 1'b0) begin miscompares++; $display("FAIL basic_done: got n_booted=%b error=%b required 0/0", bus_a.n_booted, bus_a.error); end
        vectors++; if (bus_a.rom_n_oe !== 1'b1 || bus_a.rom_addr !== 17'd6) begin miscompares++; $display("FAIL basic_rom_idle: got oe=%b addr=%h required 1/6", bus_a.rom_n_oe, bus_a.rom_addr); end
        vectors++; if (onehot_err_a !== 0) begin miscompares++; $display("FAIL basic_onehot: got %0d violations required 0", onehot_err_a); end
        // START in DONE changes nothing
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (3) @(posedge clk); #1;
        vectors++; if (bus_a.n_booted !== 1'b0 || bus_a.busy !== 1'b0 || wr_tgt_a.size() !== 2) begin miscompares++; $display("FAIL done_start_ignored: got n_booted=%b busy=%b writes=%0d required 0/0/2", bus_a.n_booted, bus_a.busy, wr_tgt_a.size()); end
    endtask

    task automatic test_zero_length();
        logic [7:0] img[$] = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h5C, 8'hFF};
        bit to;
        load_a(img);
        reset_a();
        wait_end_a(100, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL zlen_timeout: got timeout required completion"); end
        vectors++; if (wr_tgt_a.size() !== 1) begin miscompares++; $display("FAIL zlen_count: got %0d required 1", wr_tgt_a.size()); end
        if (wr_tgt_a.size() == 1) begin
            vectors++; if (wr_tgt_a[0] !== 8'd2 || wr_addr_a[0] !== 16'h0000 || wr_data_a[0] !== 8'h5C) begin miscompares++; $display("FAIL zlen_wr: got %0d/%h/%h required 2/0000/5c", wr_tgt_a[0], wr_addr_a[0], wr_data_a[0]); end
        end
        vectors++; if (bus_a.n_booted !== 1'b0) begin miscompares++; $display("FAIL zlen_done: got n_booted=%b required 0", bus_a.n_booted); end
    endtask

    task automatic test_bad_target();
        logic [7:0] img[$] = '{8'h05, 8'h00, 8'h01, 8'h11, 8'hFF};
        bit to;
        load_a(img);
        reset_a();
        wait_end_a(100, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL badtgt_timeout: got timeout required completion"); end
        vectors++; if (bus_a.error !== 1'b1 || bus_a.n_booted !== 1'b1) begin miscompares++; $display("FAIL badtgt_flags: got error=%b n_booted=%b required 1/1", bus_a.error, bus_a.n_booted); end
        vectors++; if (wr_tgt_a.size() !== 0 || bus_a.n_we !== 3'b111) begin miscompares++; $display("FAIL badtgt_writes: got %0d writes n_we=%b required 0/111", wr_tgt_a.size(), bus_a.n_we); end
        vectors++; if (bus_a.rom_addr !== 17'd1 || bus_a.rom_n_oe !== 1'b1) begin miscompares++; $display("FAIL badtgt_rom: got addr=%h oe=%b required 1/1", bus_a.rom_addr, bus_a.rom_n_oe); end
    endtask

    task automatic test_reset_in_strobe();
        logic [7:0] img[$] = '{8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'hFF};
        int strobes = 0;
        bit to;
        load_a(img);
        reset_a();
        for (int i = 0; i < 100 && strobes < 3; i++) begin
            @(posedge clk); #1;
            if (bus_a.n_we != 3'b111) strobes++;
        end
        vectors++; if (strobes !== 3) begin miscompares++; $display("FAIL rstrb_reach: got %0d strobes required 3", strobes); end
        rst_a = 1'b1;
        #1;
        vectors++; if (bus_a.n_we !== 3'b111) begin miscompares++; $display("FAIL rstrb_n_we: got %b required 111", bus_a.n_we); end
        repeat (2) @(posedge clk); #1;
        vectors++; if (wr_tgt_a.size() !== 2) begin miscompares++; $display("FAIL rstrb_prior_writes: got %0d required 2", wr_tgt_a.size()); end
        wr_tgt_a.delete(); wr_addr_a.delete(); wr_data_a.delete();
        rst_a = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus_a.rom_addr !== 17'd0 || bus_a.rom_n_oe !== 1'b0) begin miscompares++; $display("FAIL rstrb_restart: got addr=%h oe=%b required 0/0", bus_a.rom_addr, bus_a.rom_n_oe); end
        wait_end_a(100, to);
        vectors++; if (to !== 1'b0 || bus_a.n_booted !== 1'b0) begin miscompares++; $display("FAIL rstrb_done: got timeout=%b n_booted=%b required 0/0", to, bus_a.n_booted); end
        vectors++; if (wr_tgt_a.size() !== 3) begin miscompares++; $display("FAIL rstrb_count: got %0d required 3", wr_tgt_a.size()); end
        if (wr_tgt_a.size() == 3) begin
            vectors++; if (wr_addr_a[2] !== 16'h0002 || wr_data_a[2] !== 8'h33) begin miscompares++; $display("FAIL rstrb_wr2: got %h/%h required 0002/33", wr_addr_a[2], wr_data_a[2]); end
        end
    endtask

    task automatic test_rom_wait();
        logic [7:0] img[$] = '{8'h01, 8'h00, 8'h02, 8'h5A, 8'hA5, 8'hFF};
        bit to;
        bit runs_ok = 1;
        load_b(img);
        reset_b();
        repeat (5) @(posedge clk); #1;
        vectors++; if (bus_b.busy !== 1'b0 || bus_b.rom_n_oe !== 1'b1) begin miscompares++; $display("FAIL nostart_idle: got busy=%b oe=%b required 0/1", bus_b.busy, bus_b.rom_n_oe); end
        pulse_start_b();
        vectors++; if (bus_b.busy !== 1'b1 || bus_b.rom_n_oe !== 1'b0) begin miscompares++; $display("FAIL start_begin: got busy=%b oe=%b required 1/0", bus_b.busy, bus_b.rom_n_oe); end
        repeat (4) @(posedge clk); #1;
        pulse_start_b();   // START while busy has no effect
        wait_end_b(200, to);
        vectors++; if (to !== 1'b0 || bus_b.n_booted !== 1'b0) begin miscompares++; $display("FAIL wait3_done: got timeout=%b n_booted=%b required 0/0", to, bus_b.n_booted); end
        vectors++; if (wr_tgt_b.size() !== 2) begin miscompares++; $display("FAIL wait3_count: got %0d required 2", wr_tgt_b.size()); end
        if (wr_tgt_b.size() == 2) begin
            vectors++; if (wr_tgt_b[0] !== 8'd1 || wr_data_b[0] !== 8'h5A || wr_tgt_b[1] !== 8'd1 || wr_addr_b[1] !== 16'h0001 || wr_data_b[1] !== 8'hA5) begin miscompares++; $display("FAIL wait3_data: got %0d:%h %0d:%h@%h required 1:5a 1:a5@0001", wr_tgt_b[0], wr_data_b[0], wr_tgt_b[1], wr_data_b[1], wr_addr_b[1]); end
        end
        if (strobe_cyc_b.size() == 2) begin
            vectors++; if (strobe_cyc_b[1] - strobe_cyc_b[0] !== 6) begin miscompares++; $display("FAIL wait3_period: got %0d required 6", strobe_cyc_b[1] - strobe_cyc_b[0]); end
        end
        foreach (fetch_runs_b[i]) if (fetch_runs_b[i] != 3) runs_ok = 0;
        vectors++; if (fetch_runs_b.size() !== 6 || !runs_ok) begin miscompares++; $display("FAIL wait3_fetch_runs: got %0d reads (all_3=%0d) required 6 reads of 3 cycles", fetch_runs_b.size(), runs_ok); end
        vectors++; if (onehot_err_b !== 0) begin miscompares++; $display("FAIL wait3_onehot: got %0d violations required 0", onehot_err_b); end
    endtask

    task automatic test_no_wrap();
        logic [7:0] img[$];
        bit to;
        img = '{8'h00, 8'h00, 8'h0D};
        for (int i = 0; i < 13; i++) img.push_back(8'(i * 3 + 1));
        load_b(img);
        reset_b();
        pulse_start_b();
        wait_end_b(400, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL nowrap_timeout: got timeout required completion"); end
        vectors++; if (bus_b.error !== 1'b1 || bus_b.n_booted !== 1'b1 || bus_b.n_we !== 3'b111) begin miscompares++; $display("FAIL nowrap_flags: got error=%b n_booted=%b n_we=%b required 1/1/111", bus_b.error, bus_b.n_booted, bus_b.n_we); end
        vectors++; if (wr_tgt_b.size() !== 13) begin miscompares++; $display("FAIL nowrap_count: got %0d required 13", wr_tgt_b.size()); end
        if (wr_tgt_b.size() == 13) begin
            vectors++; if (wr_addr_b[12] !== 16'h000C || wr_data_b[12] !== 8'h25) begin miscompares++; $display("FAIL nowrap_last: got %h/%h required 000c/25", wr_addr_b[12], wr_data_b[12]); end
        end
        vectors++; if (wrapped_b !== 1'b0 || bus_b.rom_addr !== 4'hF) begin miscompares++; $display("FAIL nowrap_addr: got wrapped=%b addr=%h required 0/f", wrapped_b, bus_b.rom_addr); end
        vectors++; if (fetch_runs_b.size() !== 16) begin miscompares++; $display("FAIL nowrap_reads: got %0d required 16", fetch_runs_b.size()); end
        pulse_start_b();
        repeat (3) @(posedge clk); #1;
        vectors++; if (bus_b.error !== 1'b1 || bus_b.busy !== 1'b0) begin miscompares++; $display("FAIL error_start_ignored: got error=%b busy=%b required 1/0", bus_b.error, bus_b.busy); end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        test_reset();
        test_basic_image();
        test_zero_length();
        test_bad_target();
        test_reset_in_strobe();
        test_rom_wait();
        test_no_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 17, ROM address bits.
REQ-002 SHALL have parameter NUM_TARGETS, default 3, range 1..8, number of write-enable channels.
REQ-003 SHALL have parameter ROM_WAIT, default 1, range 1..7, cycles from ROM_ADDR change to valid ROM_DATA.
REQ-004 SHALL have parameter AUTOSTART, default 1; 1 = begin boot on the first cycle after reset release without START.
REQ-005 CLK  input  1  the single clock; all state changes on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 START  input  1  begin boot, sampled high for one cycle while in IDLE.
REQ-008 ROM_DATA  input  8  EEPROM read data.
REQ-009 ROM_ADDR  output  ROM_ADDR_WIDTH  EEPROM address.
REQ-010 ROM_N_OE  output  1  EEPROM output enable, active-low.
REQ-011 DATA  output  8  write data to targets.
REQ-012 ADDR  output  16  target write address.
REQ-013 N_WE  output  NUM_TARGETS  per-target write enable, active-low, one-hot-low or all high.
REQ-014 N_BOOTED  output  1  low once boot completes successfully.
REQ-015 BUSY  output  1  high while in any state other than IDLE, DONE, ERROR.
REQ-016 ERROR  output  1  high when boot aborts.

Function
REQ-017 ROM image SHALL be a sequence of segments starting at ROM address 0: header = target id byte, length high byte, length low byte, then length payload bytes.
REQ-018 Target id 0xFF SHALL terminate the image; transition to DONE.
REQ-019 Target id in NUM_TARGETS..0xFE SHALL transition to ERROR.
REQ-020 States SHALL be IDLE, FETCH, HDR_ID, HDR_LEN_HI, HDR_LEN_LO, SETUP, STROBE, HOLD, DONE, ERROR.
REQ-021 Every ROM byte read SHALL hold ROM_ADDR stable and ROM_N_OE low for exactly ROM_WAIT cycles in FETCH, then capture ROM_DATA on the following edge and increment ROM_ADDR.
REQ-022 Header bytes SHALL be consumed in HDR_ID, HDR_LEN_HI, HDR_LEN_LO, each preceded by FETCH.
REQ-023 Each segment SHALL start with ADDR = 0; ADDR SHALL increment by 1 after each HOLD.
REQ-024 Per payload byte: FETCH, then SETUP (DATA/ADDR driven, N_WE all high), STROBE (N_WE[id] low exactly one cycle), HOLD (N_WE all high, DATA/ADDR unchanged).
REQ-025 Length 0 SHALL skip the payload and fetch the next header directly.
REQ-026 Length SHALL be 16 bits; 0xFFFF is legal and writes ADDR 0x0000..0xFFFE.
REQ-027 If ROM_ADDR must advance past 2^ROM_ADDR_WIDTH-1 before a terminator, SHALL enter ERROR (no wrap-around).
REQ-028 ROM_N_OE SHALL be high in IDLE, DONE, ERROR.
REQ-029 DONE SHALL drive N_BOOTED low and hold it low until RST; START ignored.
REQ-030 ERROR SHALL drive ERROR high, N_BOOTED high, N_WE all high until RST; START ignored.
REQ-031 START while BUSY SHALL be ignored.
REQ-032 At most one N_WE bit SHALL be low on any cycle; none low outside STROBE.

Reset
REQ-033 RST high SHALL immediately force: state IDLE, N_WE all 1, N_BOOTED 1, ROM_N_OE 1, ERROR 0, ROM_ADDR 0, ADDR 0, DATA 0.
REQ-034 RST during any state including STROBE SHALL abort without further writes; boot restarts from ROM address 0.
REQ-035 With AUTOSTART=1 boot SHALL begin on the first rising edge after RST deasserts; with 0, on START.

Verification
REQ-036 Image {00,00,02,AA,BB,FF}, ROM_WAIT=1 -> N_WE[0] pulses twice, writes ADDR0=AA, ADDR1=BB; N_BOOTED low after terminator; N_WE[1],[2] never low.
REQ-037 Image {01,00,00,02,00,01,5C,FF} -> no writes for target 1, one write 5C to target 2 ADDR 0; DONE.
REQ-038 Image {05,...} with NUM_TARGETS=3 -> ERROR=1, N_BOOTED=1, no N_WE pulse.
REQ-039 ROM_ADDR_WIDTH=4, image of 16 bytes lacking 0xFF -> ERROR=1, ROM_ADDR never wraps to 0.
REQ-040 RST asserted during STROBE of 3rd byte -> N_WE all high same cycle; after release repeats full image from ROM address 0.
REQ-041 ROM_WAIT=3 -> each byte read holds ROM_ADDR 3 cycles; payload byte period 6 cycles; checker confirms one-hot-low N_WE throughout.
